// File: rtl/varint_seq.sv
// Feeds queued (value, type) descriptors to one varint encoder, packing results contiguously.
// Optional RUN watchdog is compiled in with `define VARINT_SEQ_TIMEOUT_EN.
module varint_seq #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [63:0]              push_value,
   input  logic [4:0]               push_type,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     start,
   input  logic [63:0]              base_addr,
   output logic                     busy,
   output logic                     done,
   output logic [63:0]              next_addr,
   output logic [15:0]              total_bytes,
   output logic                     overflow,
   output logic                     error,
   output logic                     enc_reset,
   output logic                     enc_en,
   output logic [63:0]              enc_value,
   output logic [4:0]               enc_type,
   output logic [63:0]              enc_dst_addr,
   input  logic                     enc_done,
   input  logic [3:0]               enc_bytes
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, CLR, RUN, ADV, FIN} state_t;

   state_t        state;
   logic [63:0]   mem_value [DEPTH];
   logic [4:0]    mem_type  [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   cnt;
   logic [3:0]    cap;
   logic [63:0]   cur_addr;

   logic          pop;
   logic          flush;
   logic          push_ok;
   logic          drop;
   logic          more;
   logic          timeout;
   logic [16:0]   sum;
   logic [63:0]   adv_addr;

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign count = cnt;

`ifdef VARINT_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer;

   assign timeout = (state == RUN) && !enc_done &&
                    (timer == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= '0;
         error <= 1'b0;
      end else begin
         if (state == CLR)
            timer <= '0;
         else if (state == RUN)
            timer <= timer + TW'(1);
         if (timeout)
            error <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   always_comb begin
      pop      = (state == ADV);
      flush    = timeout;
      push_ok  = push && !flush && (!full || pop);
      drop     = push && full && !pop;
      // in ADV the popped head is the last entry unless a push lands now
      more     = (cnt != (AW+1)'(1)) || push_ok;
      sum      = {1'b0, total_bytes} + {13'b0, cap};
      adv_addr = cur_addr + {60'b0, cap};
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_value[wr_ptr] <= push_value;
         mem_type[wr_ptr]  <= push_type;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (flush) begin
            rd_ptr <= wr_ptr;
            cnt    <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
         end
         if (drop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         next_addr    <= '0;
         total_bytes  <= '0;
         cur_addr     <= '0;
         cap          <= '0;
         enc_reset    <= 1'b1;
         enc_en       <= 1'b0;
         enc_value    <= '0;
         enc_type     <= '0;
         enc_dst_addr <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  cur_addr    <= base_addr;
                  total_bytes <= '0;
                  if (cnt != '0) begin
                     busy  <= 1'b1;
                     state <= CLR;
                  end else begin
                     done      <= 1'b1;
                     next_addr <= base_addr;
                     state     <= FIN;
                  end
               end
            end
            CLR: begin
               enc_reset    <= 1'b0;
               enc_en       <= 1'b1;
               enc_value    <= mem_value[rd_ptr];
               enc_type     <= mem_type[rd_ptr];
               enc_dst_addr <= cur_addr;
               state        <= RUN;
            end
            RUN: begin
               if (timeout) begin
                  enc_en    <= 1'b0;
                  enc_reset <= 1'b1;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  next_addr <= cur_addr;
                  state     <= FIN;
               end else if (enc_done) begin
                  cap       <= enc_bytes;
                  enc_en    <= 1'b0;
                  enc_reset <= 1'b1;
                  state     <= ADV;
               end
            end
            ADV: begin
               cur_addr    <= adv_addr;
               total_bytes <= sum[16] ? 16'hFFFF : sum[15:0];
               if (more) begin
                  state <= CLR;
               end else begin
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  next_addr <= adv_addr;
                  state     <= FIN;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/varint_seq.md
Name: varint_seq

Overview:
- Scheduler that feeds a queue of (value, field_type) descriptors to one top_varint encoder instance back-to-back.
- Packs the encoded varints contiguously in DRAM, starting at a base address. Each field's destination is the previous destination plus the previous bytes_written.
- Sits between the message-level serializer control and top_varint. It owns the encoder's reset/en/value/field_type/dst_addr inputs and consumes its done/bytes_written.

Parameters:
- DEPTH, 4, descriptor FIFO entries (power of 2, >=2)
- TIMEOUT_CYCLES, 64, watchdog limit per field (used only with the optional feature)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- push  input  1  enqueue descriptor this cycle
- push_value  input  64  value to encode
- push_type  input  5  field type
- full  output  1  FIFO full
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- start  input  1  begin draining FIFO at base_addr
- base_addr  input  64  first destination address
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse at sequence end
- next_addr  output  64  base_addr + total_bytes (valid when done)
- total_bytes  output  16  bytes emitted this sequence
- overflow  output  1  sticky: push while full
- error  output  1  sticky: watchdog fired (tied 0 without the feature)
- enc_reset  output  1  to top_varint reset
- enc_en  output  1  to top_varint en
- enc_value  output  64  to top_varint value
- enc_type  output  5  to top_varint field_type
- enc_dst_addr  output  64  to top_varint dst_addr
- enc_done  input  1  from top_varint done
- enc_bytes  input  4  from top_varint bytes_written

Behaviour:
- Reset (async, immediate):
  - FIFO emptied; state IDLE.
  - busy, done, overflow and error are 0; total_bytes = 0; next_addr = 0.
  - enc_en = 0; enc_reset = 1; enc_value, enc_type and enc_dst_addr are 0.
- FIFO:
  - Synchronous; push accepted when !full.
  - Push while full is dropped and sets overflow.
  - Push is allowed in any state, including while busy; pushed entries join the current sequence.
  - Simultaneous push and pop when full is legal and the push is accepted.
- FSM states: IDLE, CLR, RUN, ADV, FIN.
- IDLE:
  - enc_reset = 1, enc_en = 0.
  - On start with FIFO non-empty: latch cur_addr = base_addr, clear total_bytes, set busy, go to CLR.
  - On start with FIFO empty: go to FIN (no encoder activity).
  - start is ignored when not in IDLE.
- CLR: one cycle with enc_reset = 1 and enc_en = 0; go to RUN.
- RUN:
  - enc_reset = 0, enc_en = 1.
  - enc_value and enc_type come from the FIFO head; enc_dst_addr = cur_addr.
  - All encoder inputs are held stable until enc_done.
  - On enc_done: capture enc_bytes, go to ADV.
- ADV (one cycle):
  - enc_en = 0, enc_reset = 1.
  - Pop the head; cur_addr += captured bytes (64-bit wrap); total_bytes += bytes (16-bit saturating).
  - If the FIFO is empty after the pop and no same-cycle push is accepted, go to FIN; otherwise go to CLR.
- FIN:
  - done = 1 for exactly one cycle; next_addr = cur_addr; busy drops.
  - Go to IDLE.
  - next_addr and total_bytes hold until the next start.
- enc_bytes > 10 is recorded unchanged (no check).
- Latency per field: 1 (CLR) + encoder latency + 1 (ADV). Back-to-back fields have no extra idle cycles.
- enc_done outside RUN is ignored.

Optional Feature:
- Macro: VARINT_SEQ_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs in RUN and clears on entry to RUN.
  - If it reaches TIMEOUT_CYCLES without enc_done: set error, flush the FIFO, go to FIN (done still pulses).
  - next_addr = cur_addr at the abort point.
- Disabled: no counter; error is tied 0; RUN waits indefinitely.

Test Plan:
- Push (150, type 5), (0xFFFFFFFF, 5), (0xFFFF_FFFF_FFFF_FFFF, 3); start with base_addr = 0x100.
  - enc_dst_addr goes 0x100, 0x102, 0x107.
  - done pulses once; total_bytes = 17; next_addr = 0x111.
  - DRAM 0x100–0x110 holds 96 01 | FF FF FF FF 0F | FF×9 01.
- Start with an empty FIFO → done pulses the cycle after FIN entry; enc_en never asserts; total_bytes = 0; next_addr = base_addr.
- Push a 5th descriptor with DEPTH = 4 while idle → full = 1; overflow sets; count stays 4; first 4 entries encode correctly.
- During RUN of field 1 of 1, push another descriptor → sequence continues with no gap beyond the CLR cycle; done pulses after both; total_bytes is the sum of both.
- Assert reset mid-RUN → outputs go to reset values asynchronously; FIFO is empty; a later start with new pushes behaves normally.
- With VARINT_SEQ_TIMEOUT_EN and a stub encoder that never raises done, TIMEOUT_CYCLES = 8 → error = 1 after 8 RUN cycles; FIFO is flushed; done pulses; next_addr = base_addr.
